// File: rtl/mcu_isa_pkg.sv
// ISA definitions shared by the instruction decoder: field positions, opcode classes,
// ALU function codes and the registered decode bundle.
package mcu_isa_pkg;

    localparam int NUM_REGS   = 8;
    localparam int JMP_ADDR_W = 4;
    localparam int ALU_FUNC_W = 3;
    localparam int SRC_W      = 4;
    localparam int IMM_W      = 4;

    // Opcode prefixes (MSBs of the instruction word)
    localparam logic       OPC_LOAD = 1'b0;
    localparam logic [1:0] OPC_MOV  = 2'b10;
    localparam logic [2:0] OPC_ALU  = 3'b110;
    localparam logic [3:0] OPC_JMP  = 4'b1110;
    localparam logic [3:0] OPC_JNZ  = 4'b1111;

    // Field bit positions
    localparam int LOAD_D_HI = 6, LOAD_D_LO = 4;
    localparam int IMM_HI    = 3, IMM_LO    = 0;
    localparam int MOV_D_HI  = 5, MOV_D_LO  = 3;
    localparam int MOV_S_HI  = 2, MOV_S_LO  = 0;
    localparam int ALU_F_HI  = 4, ALU_F_LO  = 2;
    localparam int ALU_X_BIT = 1, ALU_Y_BIT = 0;
    localparam int JADDR_HI  = 3, JADDR_LO  = 0;

    localparam logic [2:0] REG_R0 = 3'd0, REG_R1 = 3'd1, REG_R2 = 3'd2, REG_R3 = 3'd3;
    localparam logic [2:0] REG_R4 = 3'd4, REG_R5 = 3'd5, REG_R6 = 3'd6, REG_R7 = 3'd7;
    localparam logic [SRC_W-1:0] SRC_IMM = 4'h8;

    typedef enum logic [ALU_FUNC_W-1:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
        ALU_XOR = 3'd4, ALU_NOT = 3'd5, ALU_SHL = 3'd6, ALU_SHR = 3'd7
    } alu_func_e;

    typedef enum logic [2:0] { OP_LOAD, OP_MOV, OP_ALU, OP_JMP, OP_JNZ } op_class_e;

    typedef struct packed {
        logic [NUM_REGS-1:0] reg_en;
        logic [SRC_W-1:0]    src_sel;
        logic [IMM_W-1:0]    imm;
        alu_func_e           alu_func;
        logic                alu_xsel;
        logic                alu_ysel;
        logic                alu_en;
        logic                i_valid;
    } decoded_t;

    // Every one of the 256 encodings lands in exactly one class.
    function automatic op_class_e op_class(input logic [7:0] ir);
        if (ir[7] == OPC_LOAD)          return OP_LOAD;
        else if (ir[7:6] == OPC_MOV)    return OP_MOV;
        else if (ir[7:5] == OPC_ALU)    return OP_ALU;
        else if (ir[7:4] == OPC_JMP)    return OP_JMP;
        else                            return OP_JNZ;
    endfunction

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [2:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/zero_flag_tracker.sv
// Zero flag owner: captures the ALU zero result one cycle after an ALU decode and
// bypasses that fresh result to dont_jump so an immediately following JNZ sees it.
module zero_flag_tracker (
    input  logic clk,
    input  logic sync_reset_n,
    input  logic alu_decoded,
    input  logic alu_zero,
    output logic dont_jump
);

    logic alu_pending_d, alu_pending_q;
    logic zero_flag_d, zero_flag_q;

    always_comb begin
        alu_pending_d = alu_decoded;
        zero_flag_d   = alu_pending_q ? alu_zero : zero_flag_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            alu_pending_q <= 1'b0;
            zero_flag_q   <= 1'b0;
        end else begin
            alu_pending_q <= alu_pending_d;
            zero_flag_q   <= zero_flag_d;
        end
    end

    assign dont_jump = zero_flag_d;

endmodule

// File: rtl/instruction_decoder.sv
// Decodes the program ROM word: jump controls are combinational for a bubble-free
// redirect, datapath controls pass through one register stage.
module instruction_decoder
    import mcu_isa_pkg::*;
(
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic [7:0]            pm_data,
    input  logic                  alu_zero,
    output logic                  jmp,
    output logic                  jmp_nz,
    output logic [JMP_ADDR_W-1:0] jmp_addr,
    output logic                  dont_jump,
    output logic [NUM_REGS-1:0]   reg_en,
    output logic [SRC_W-1:0]      src_sel,
    output logic [IMM_W-1:0]      imm,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic                  alu_xsel,
    output logic                  alu_ysel,
    output logic                  alu_en,
    output logic                  i_valid
);

    decoded_t  dec_d, dec_q;
    op_class_e op;
    logic      alu_decoded;
    logic [2:0] mov_d, mov_s;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves
        // a signal unassigned and no latch is inferred.
        dec_d       = '0;
        jmp         = 1'b0;
        jmp_nz      = 1'b0;
        jmp_addr    = '0;
        alu_decoded = 1'b0;
        op          = op_class(pm_data);
        mov_d       = pm_data[MOV_D_HI:MOV_D_LO];
        mov_s       = pm_data[MOV_S_HI:MOV_S_LO];

        if (sync_reset_n) begin
            dec_d.i_valid = 1'b1;
            jmp_addr      = pm_data[JADDR_HI:JADDR_LO];
            case (op)
                OP_LOAD: begin
                    dec_d.reg_en  = reg_onehot(pm_data[LOAD_D_HI:LOAD_D_LO]);
                    dec_d.src_sel = SRC_IMM;
                    dec_d.imm     = pm_data[IMM_HI:IMM_LO];
                end
                OP_MOV: begin
                    // d == s degenerates to a NOP that still counts as accepted
                    dec_d.reg_en  = (mov_d == mov_s) ? '0 : reg_onehot(mov_d);
                    dec_d.src_sel = {1'b0, mov_s};
                end
                OP_ALU: begin
                    dec_d.alu_en   = 1'b1;
                    dec_d.alu_func = alu_func_e'(pm_data[ALU_F_HI:ALU_F_LO]);
                    dec_d.alu_xsel = pm_data[ALU_X_BIT];
                    dec_d.alu_ysel = pm_data[ALU_Y_BIT];
                    alu_decoded    = 1'b1;
                end
                OP_JMP:  jmp    = 1'b1;
                OP_JNZ:  jmp_nz = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) dec_q <= '0;
        else               dec_q <= dec_d;
    end

    zero_flag_tracker u_zero_flag_tracker (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .alu_decoded  (alu_decoded),
        .alu_zero     (alu_zero),
        .dont_jump    (dont_jump)
    );

    assign reg_en   = dec_q.reg_en;
    assign src_sel  = dec_q.src_sel;
    assign imm      = dec_q.imm;
    assign alu_func = dec_q.alu_func;
    assign alu_xsel = dec_q.alu_xsel;
    assign alu_ysel = dec_q.alu_ysel;
    assign alu_en   = dec_q.alu_en;
    assign i_valid  = dec_q.i_valid;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: same-cycle jump outputs checked directly,
// registered outputs checked one cycle later through a scoreboard queue.
module tb_instruction_decoder;

    logic       clk = 1'b0;
    logic       sync_reset_n = 1'b0;
    logic [7:0] pm_data = 8'h00;
    logic       alu_zero = 1'b0;
    logic       jmp, jmp_nz, dont_jump;
    logic [3:0] jmp_addr, src_sel, imm;
    logic [7:0] reg_en;
    logic [2:0] alu_func;
    logic       alu_xsel, alu_ysel, alu_en, i_valid;

    instruction_decoder dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .pm_data      (pm_data),
        .alu_zero     (alu_zero),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .jmp_addr     (jmp_addr),
        .dont_jump    (dont_jump),
        .reg_en       (reg_en),
        .src_sel      (src_sel),
        .imm          (imm),
        .alu_func     (alu_func),
        .alu_xsel     (alu_xsel),
        .alu_ysel     (alu_ysel),
        .alu_en       (alu_en),
        .i_valid      (i_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] reg_en;
        logic [3:0] src_sel;
        logic [3:0] imm;
        logic [2:0] alu_func;
        logic       alu_xsel;
        logic       alu_ysel;
        logic       alu_en;
        logic       i_valid;
    } exp_reg_t;

    typedef struct {
        string    tag;
        exp_reg_t r;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_asserts = 0;
    int       n_fail    = 0;
    logic     m_pending = 1'b0;
    logic     m_zero    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected registered outputs, written straight from the encoding table.
    function automatic exp_reg_t model_reg(input logic rn, input logic [7:0] ir);
        exp_reg_t m = '0;
        if (rn) begin
            m.i_valid = 1'b1;
            if (ir[7] == 1'b0) begin
                m.reg_en  = 8'h01 << ir[6:4];
                m.src_sel = 4'h8;
                m.imm     = ir[3:0];
            end else if (ir[6] == 1'b0) begin
                if (ir[5:3] != ir[2:0]) m.reg_en = 8'h01 << ir[5:3];
                m.src_sel = {1'b0, ir[2:0]};
            end else if (ir[5] == 1'b0) begin
                m.alu_en   = 1'b1;
                m.alu_func = ir[4:2];
                m.alu_xsel = ir[1];
                m.alu_ysel = ir[0];
            end
        end
        return m;
    endfunction

    // One decode cycle. exp_dj >= 0 adds a hard-coded dont_jump expectation.
    task automatic cycle(input string tag, input logic rn, input logic [7:0] ir,
                         input logic az, input int exp_dj = -1);
        logic     dj;
        sb_item_t it;
        @(negedge clk);
        sync_reset_n = rn;
        pm_data      = ir;
        alu_zero     = az;
        #1;
        dj = m_pending ? az : m_zero;
        check({tag, "_jmp"},      32'(jmp),      32'(rn && ir[7:4] == 4'hE));
        check({tag, "_jmp_nz"},   32'(jmp_nz),   32'(rn && ir[7:4] == 4'hF));
        check({tag, "_jmp_addr"}, 32'(jmp_addr), 32'(rn ? ir[3:0] : 4'h0));
        check({tag, "_dont_jump"}, 32'(dont_jump), 32'(dj));
        if (exp_dj >= 0) check({tag, "_dont_jump_const"}, 32'(dont_jump), 32'(exp_dj));
        sb.push_back('{tag: tag, r: model_reg(rn, ir)});
        m_zero    = rn ? dj : 1'b0;
        m_pending = rn && (ir[7:5] == 3'b110);
        @(posedge clk);
        #1;
        it = sb.pop_front();
        check({it.tag, "_regs"},
              32'({reg_en, src_sel, imm, alu_func, alu_xsel, alu_ysel, alu_en, i_valid}),
              32'(it.r));
    endtask

    initial begin
        // Reset holds jumps and registered outputs low, then a JMP decodes at once
        cycle("t1_rst0", 1'b0, 8'hE5, 1'b0);
        cycle("t1_rst1", 1'b0, 8'hE5, 1'b0);
        check("t1_reg_en_rst", 32'(reg_en), 32'h0);
        check("t1_i_valid_rst", 32'(i_valid), 32'h0);
        cycle("t1_jmp", 1'b1, 8'hE5, 1'b0);
        check("t1_i_valid_after", 32'(i_valid), 32'h1);

        cycle("t2_load", 1'b1, 8'h3A, 1'b0);
        check("t2_reg_en", 32'(reg_en), 32'h08);
        check("t2_src_sel", 32'(src_sel), 32'h8);
        check("t2_imm", 32'(imm), 32'hA);

        cycle("t3_mov", 1'b1, 8'h99, 1'b0);
        check("t3_mov_reg_en", 32'(reg_en), 32'h08);
        check("t3_mov_src_sel", 32'(src_sel), 32'h1);
        cycle("t3_nop", 1'b1, 8'h9B, 1'b0);
        check("t3_nop_reg_en", 32'(reg_en), 32'h0);
        check("t3_nop_i_valid", 32'(i_valid), 32'h1);

        // ALU then JNZ: the fresh zero result is bypassed to dont_jump
        cycle("t4_alu", 1'b1, 8'hC6, 1'b0);
        check("t4_alu_en", 32'(alu_en), 32'h1);
        cycle("t4_jnz", 1'b1, 8'hF4, 1'b1, 1);

        // Flag holds through non-ALU instructions; alu_zero is ignored when not pending
        cycle("t5_load", 1'b1, 8'h12, 1'b0, 1);
        cycle("t5_mov", 1'b1, 8'hA8, 1'b0, 1);
        cycle("t5_jnz", 1'b1, 8'hF2, 1'b0, 1);
        cycle("t5_alu", 1'b1, 8'hD3, 1'b0);
        cycle("t5_jnz0", 1'b1, 8'hF7, 1'b0, 0);
        cycle("t5_b2b_a", 1'b1, 8'hC0, 1'b0);
        cycle("t5_b2b_b", 1'b1, 8'hDF, 1'b1, 1);
        cycle("t5_b2b_jnz", 1'b1, 8'hF1, 1'b0, 0);
        cycle("t5_jmp_hold", 1'b1, 8'hE3, 1'b1, 0);

        // Reset mid-operation discards the pending ALU result
        cycle("t6_alu", 1'b1, 8'hC8, 1'b0);
        cycle("t6_rst", 1'b0, 8'h00, 1'b1);
        cycle("t6_jnz", 1'b1, 8'hF9, 1'b1, 0);
        cycle("t6_rst_alu", 1'b0, 8'hC4, 1'b1);
        cycle("t6_jnz2", 1'b1, 8'hF0, 1'b1, 0);
        cycle("t6_set", 1'b1, 8'hCD, 1'b0);
        cycle("t6_set_jnz", 1'b1, 8'hF6, 1'b1, 1);
        cycle("t6_rst_hold", 1'b0, 8'hF6, 1'b0);
        cycle("t6_cleared", 1'b1, 8'hFA, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            cycle($sformatf("rnd%0d", i), 1'b1, 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
